// File: rtl/fir_sample_pacer.sv
// fir_sample_pacer
//   Buffers signed samples from a valid/ready producer in a small circular
//   FIFO and issues them to the FIR filter as single-cycle data_en strobes.
//   After each strobe the block idles for a programmable number of cycles
//   (gap), so the sample rate seen by the filter is deterministic.
//
//   Optional feature: define PACER_FLUSH_EN to add a synchronous 'flush'
//   input that empties the FIFO and cancels any strobe in progress.
//   The default build (macro undefined) has no flush port.

module fir_sample_pacer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int GAP_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef PACER_FLUSH_EN
  input  logic                      flush,
`endif
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      enable,
  input  logic [GAP_W-1:0]          gap,
  output logic                      data_en,
  output logic signed [DATA_W-1:0]  data,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      busy
);

  localparam int PTR_W = $clog2(DEPTH);

  // Typed constants keep comparisons width-exact.
  localparam logic [PTR_W:0] LVL_ZERO = '0;
  localparam logic [PTR_W:0] LVL_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [GAP_W-1:0] GAP_ZERO = '0;
  localparam logic [GAP_W-1:0] GAP_ONE  = (GAP_W)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_nx;
  logic [GAP_W-1:0]         gap_cnt;
  logic [GAP_W-1:0]         gap_cnt_nx;

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W:0]           count;

  logic                     full;
  logic                     push;
  logic                     pop;
  logic                     flush_i;

`ifdef PACER_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // A full FIFO refuses pushes even when a pop happens on the same edge,
  // so a write can never land on the slot being read.
  assign full     = (count == LVL_FULL);
  assign in_ready = !full;
  assign push     = in_valid && !full && !flush_i;
  // ISSUE is only ever entered with at least one entry buffered.
  assign pop      = (state == ISSUE);

  assign level = count;
  assign busy  = (state != IDLE) || (count != LVL_ZERO);

  // Sample storage: plain array, written on push, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + LVL_ONE;
        2'b01:   count <= count - LVL_ONE;
        default: count <= count;
      endcase
    end
  end

  // Next-state logic for the strobe pacing machine.
  // In ISSUE the head is being popped, so "still non-empty" means more
  // than one entry is present before the pop.
  always_comb begin
    state_nx   = state;
    gap_cnt_nx = gap_cnt;
    case (state)
      IDLE: begin
        if (enable && (count != LVL_ZERO)) begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        gap_cnt_nx = gap;
        if (gap != GAP_ZERO) begin
          state_nx = GAP;
        end else if (enable && (count > LVL_ONE)) begin
          state_nx = ISSUE;
        end else begin
          state_nx = IDLE;
        end
      end
      GAP: begin
        gap_cnt_nx = gap_cnt - 1'b1;
        // Counter runs gap..1; the last gap cycle decides what follows.
        if (gap_cnt <= GAP_ONE) begin
          if (enable && (count != LVL_ZERO)) begin
            state_nx = ISSUE;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, gap counter and the registered strobe/data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
      data_en <= 1'b0;
      data    <= '0;
    end else if (flush_i) begin
      state   <= IDLE;
      gap_cnt <= '0;
      data_en <= 1'b0;
      data    <= '0;
    end else begin
      state   <= state_nx;
      gap_cnt <= gap_cnt_nx;
      data_en <= pop;
      data    <= pop ? mem[rd_ptr] : '0;
    end
  end

endmodule
